// File: rtl/uart_rx_ctrl.sv
// UART receive bit-timing controller: start qualification, mid-bit sampling, stop check.
// Optional even-parity bit support is enabled by defining RX_PARITY_EN.
module uart_rx_ctrl #(
    parameter int WIDTH      = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic baud_tick,
    input  logic RX_in,
    output logic RX_data,
    output logic shift_bit,
    output logic rx_done,
    output logic frame_err,
    output logic busy,
    output logic parity_err
);

    localparam int TICK_W = $clog2(OVERSAMPLE);
    localparam int BIT_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [TICK_W-1:0] MID_START = TICK_W'(OVERSAMPLE / 2 - 1);
    localparam logic [TICK_W-1:0] LAST_TICK = TICK_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef RX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t             state, state_n;
    logic               rx_meta, rx_s;
    logic [TICK_W-1:0]  tick_cnt, tick_n;
    logic [BIT_W-1:0]   bit_cnt, bit_n;
    logic               data_n, shift_n, done_n, ferr_n, busy_n;
`ifdef RX_PARITY_EN
    logic               par_acc, par_n;
    logic               perr_q, perr_n;
`endif

    always_comb begin
        state_n = state;
        tick_n  = tick_cnt;
        bit_n   = bit_cnt;
        data_n  = RX_data;
        shift_n = 1'b0;
        done_n  = 1'b0;
        ferr_n  = frame_err;
        busy_n  = busy;
`ifdef RX_PARITY_EN
        par_n   = par_acc;
        perr_n  = perr_q;
`endif
        if (baud_tick) begin
            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state_n = START;
                        tick_n  = '0;
                        busy_n  = 1'b1;
                        ferr_n  = 1'b0;
`ifdef RX_PARITY_EN
                        perr_n  = 1'b0;
`endif
                    end
                end
                START: begin
                    if (tick_cnt == MID_START) begin
                        tick_n = '0;
                        if (!rx_s) begin
                            state_n = DATA;
                            bit_n   = '0;
`ifdef RX_PARITY_EN
                            par_n   = 1'b0;
`endif
                        end else begin
                            // Line went back high before mid start bit: treat as noise.
                            state_n = IDLE;
                            busy_n  = 1'b0;
                        end
                    end else begin
                        tick_n = tick_cnt + TICK_W'(1);
                    end
                end
                DATA: begin
                    if (tick_cnt == LAST_TICK) begin
                        data_n  = rx_s;
                        shift_n = 1'b1;
                        tick_n  = '0;
`ifdef RX_PARITY_EN
                        par_n   = par_acc ^ rx_s;
`endif
                        if (bit_cnt == LAST_BIT) begin
`ifdef RX_PARITY_EN
                            state_n = PARITY;
`else
                            state_n = STOP;
`endif
                        end else begin
                            bit_n = bit_cnt + BIT_W'(1);
                        end
                    end else begin
                        tick_n = tick_cnt + TICK_W'(1);
                    end
                end
`ifdef RX_PARITY_EN
                PARITY: begin
                    if (tick_cnt == LAST_TICK) begin
                        perr_n  = par_acc ^ rx_s;
                        tick_n  = '0;
                        state_n = STOP;
                    end else begin
                        tick_n = tick_cnt + TICK_W'(1);
                    end
                end
`endif
                STOP: begin
                    // Leave at mid stop bit so a following start edge is never missed.
                    if (tick_cnt == LAST_TICK) begin
                        done_n  = 1'b1;
                        ferr_n  = ~rx_s;
                        busy_n  = 1'b0;
                        tick_n  = '0;
                        state_n = IDLE;
                    end else begin
                        tick_n = tick_cnt + TICK_W'(1);
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta   <= 1'b1;
            rx_s      <= 1'b1;
            state     <= IDLE;
            tick_cnt  <= '0;
            bit_cnt   <= '0;
            RX_data   <= 1'b1;
            shift_bit <= 1'b0;
            rx_done   <= 1'b0;
            frame_err <= 1'b0;
            busy      <= 1'b0;
`ifdef RX_PARITY_EN
            par_acc   <= 1'b0;
            perr_q    <= 1'b0;
`endif
        end else begin
            rx_meta   <= RX_in;
            rx_s      <= rx_meta;
            state     <= state_n;
            tick_cnt  <= tick_n;
            bit_cnt   <= bit_n;
            RX_data   <= data_n;
            shift_bit <= shift_n;
            rx_done   <= done_n;
            frame_err <= ferr_n;
            busy      <= busy_n;
`ifdef RX_PARITY_EN
            par_acc   <= par_n;
            perr_q    <= perr_n;
`endif
        end
    end

`ifdef RX_PARITY_EN
    assign parity_err = perr_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl (WIDTH=8, OVERSAMPLE=16, baud_tick every clk).
module tb_uart_rx_ctrl;

    localparam int OS = 16;

    logic clk = 1'b0;
    logic rst, baud_tick, RX_in;
    logic RX_data, shift_bit, rx_done, frame_err, busy, parity_err;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;

    int         strobe_cnt = 0;
    int         done_cnt = 0;
    int         strobe_t [0:255];
    logic [7:0] byte_log [0:63];
    logic [7:0] sipo = 8'h00;
    logic       ferr_log = 1'b0;
`ifdef RX_PARITY_EN
    logic       par_flip = 1'b0;
`endif

    uart_rx_ctrl #(.WIDTH(8), .OVERSAMPLE(OS)) dut (
        .clk        (clk),
        .rst        (rst),
        .baud_tick  (baud_tick),
        .RX_in      (RX_in),
        .RX_data    (RX_data),
        .shift_bit  (shift_bit),
        .rx_done    (rx_done),
        .frame_err  (frame_err),
        .busy       (busy),
        .parity_err (parity_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural SIPO and event log, sampled away from the active edge.
    always @(negedge clk) begin
        if (shift_bit) begin
            strobe_t[strobe_cnt & 255] <= cyc;
            strobe_cnt <= strobe_cnt + 1;
            sipo <= {RX_data, sipo[7:1]};
        end
        if (rx_done) begin
            byte_log[done_cnt & 63] <= sipo;
            ferr_log <= frame_err;
            done_cnt <= done_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        RX_in = b;
        idle(OS);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef RX_PARITY_EN
        send_bit((^d) ^ par_flip);
`endif
        send_bit(stop);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int s0, d0, lat, t0;
        bit seen;

        // Reset
        rst = 1'b1; RX_in = 1'b1; baud_tick = 1'b1;
        idle(2);
        chk("rst_rx_data", {31'd0, RX_data}, 32'd1);
        chk("rst_shift", {31'd0, shift_bit}, 32'd0);
        chk("rst_done", {31'd0, rx_done}, 32'd0);
        chk("rst_ferr", {31'd0, frame_err}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_perr", {31'd0, parity_err}, 32'd0);
        rst = 1'b0;
        idle(10);

        // Nominal frame 0xB5 with latency measurement
        s0 = strobe_cnt; d0 = done_cnt; lat = -1;
        fork
            send_frame(8'hB5, 1'b1);
            begin
                t0 = cyc;
                for (int i = 0; i < 200; i++) begin
                    @(negedge clk);
                    if (shift_bit) begin
                        lat = cyc - t0;
                        break;
                    end
                end
            end
        join
        idle(4);
        chk("b5_latency", lat, 27);
        chk("b5_strobes", strobe_cnt - s0, 8);
        chk("b5_span", strobe_t[(s0 + 7) & 255] - strobe_t[s0 & 255], 7 * OS);
        chk("b5_byte", {24'd0, byte_log[d0 & 63]}, 32'hB5);
        chk("b5_done", done_cnt - d0, 1);
        chk("b5_ferr", {31'd0, ferr_log}, 32'd0);
        chk("b5_busy_end", {31'd0, busy}, 32'd0);

        // Glitch shorter than half a bit
        s0 = strobe_cnt; d0 = done_cnt;
        RX_in = 1'b0;
        idle(4);
        RX_in = 1'b1;
        chk("glitch_busy_up", {31'd0, busy}, 32'd1);
        idle(10);
        chk("glitch_busy_down", {31'd0, busy}, 32'd0);
        chk("glitch_strobes", strobe_cnt - s0, 0);
        chk("glitch_done", done_cnt - d0, 0);
        idle(10);

        // Framing error on 0x3C, then a clean 0x00
        s0 = strobe_cnt; d0 = done_cnt;
        send_frame(8'h3C, 1'b0);
        RX_in = 1'b1;
        idle(20);
        chk("ferr_strobes", strobe_cnt - s0, 8);
        chk("ferr_byte", {24'd0, byte_log[d0 & 63]}, 32'h3C);
        chk("ferr_done", done_cnt - d0, 1);
        chk("ferr_flag", {31'd0, ferr_log}, 32'd1);
        s0 = strobe_cnt; d0 = done_cnt;
        send_frame(8'h00, 1'b1);
        idle(4);
        chk("z_strobes", strobe_cnt - s0, 8);
        chk("z_byte", {24'd0, byte_log[d0 & 63]}, 32'h00);
        chk("z_ferr_at_done", {31'd0, ferr_log}, 32'd0);
        chk("z_ferr_now", {31'd0, frame_err}, 32'd0);

        // Reset after the third strobe of 0x03 (third bit is 0)
        s0 = strobe_cnt; d0 = done_cnt;
        fork
            send_frame(8'h03, 1'b1);
            begin
                seen = 1'b0;
                for (int i = 0; i < 300; i++) begin
                    @(negedge clk);
                    if (strobe_cnt - s0 >= 3) begin
                        seen = 1'b1;
                        break;
                    end
                end
                chk("mid_rst_3rd_strobe", {31'd0, seen}, 32'd1);
                @(posedge clk); #1;
                rst = 1'b1;
                idle(1);
                chk("mid_rst_busy", {31'd0, busy}, 32'd0);
                chk("mid_rst_rx_data", {31'd0, RX_data}, 32'd1);
                chk("mid_rst_shift", {31'd0, shift_bit}, 32'd0);
            end
        join
        chk("mid_rst_no_done", done_cnt - d0, 0);
        rst = 1'b0;
        idle(5);
        s0 = strobe_cnt; d0 = done_cnt;
        send_frame(8'hA5, 1'b1);
        idle(4);
        chk("a5_strobes", strobe_cnt - s0, 8);
        chk("a5_byte", {24'd0, byte_log[d0 & 63]}, 32'hA5);
        chk("a5_done", done_cnt - d0, 1);

        // Back-to-back frames, no idle gap
        d0 = done_cnt;
        send_frame(8'h5A, 1'b1);
        send_frame(8'hC3, 1'b1);
        idle(4);
        chk("b2b_done", done_cnt - d0, 2);
        chk("b2b_byte0", {24'd0, byte_log[d0 & 63]}, 32'h5A);
        chk("b2b_byte1", {24'd0, byte_log[(d0 + 1) & 63]}, 32'hC3);

`ifdef RX_PARITY_EN
        // 0x07 has odd weight: parity bit 1 is correct, parity bit 0 is an error
        s0 = strobe_cnt;
        par_flip = 1'b0;
        send_frame(8'h07, 1'b1);
        idle(4);
        chk("par_ok_strobes", strobe_cnt - s0, 8);
        chk("par_ok_perr", {31'd0, parity_err}, 32'd0);
        s0 = strobe_cnt;
        par_flip = 1'b1;
        send_frame(8'h07, 1'b1);
        idle(4);
        chk("par_bad_strobes", strobe_cnt - s0, 8);
        chk("par_bad_perr", {31'd0, parity_err}, 32'd1);
        par_flip = 1'b0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
